// File: rtl/queue_int_if.sv
// queue_int_if: dispatch/CDB/issue bundle of the integer queue; slave = queue side, master = driver side
interface queue_int_if #(parameter int TAGW = 6);
  logic            dispatch_en;
  logic            dispatch_ready;
  logic [2:0]      dispatch_opcode;
  logic [15:0]     dispatch_imm;
  logic [TAGW-1:0] dispatch_rdtag;
  logic [TAGW-1:0] dispatch_rstag;
  logic [TAGW-1:0] dispatch_rttag;
  logic [31:0]     dispatch_rsdata;
  logic [31:0]     dispatch_rtdata;
  logic            dispatch_rsvalid;
  logic            dispatch_rtvalid;
  logic            cdb_valid;
  logic [TAGW-1:0] cdb_tag;
  logic [31:0]     cdb_data;
  logic            issue_valid;
  logic            issue_ready;
  logic [2:0]      issue_opcode;
  logic [15:0]     issue_imm;
  logic [TAGW-1:0] issue_rdtag;
  logic [31:0]     issue_rsdata;
  logic [31:0]     issue_rtdata;
  modport slave(
    input  dispatch_en, dispatch_opcode, dispatch_imm, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
           dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    output dispatch_ready, issue_valid, issue_opcode, issue_imm, issue_rdtag, issue_rsdata, issue_rtdata
  );
  modport master(
    output dispatch_en, dispatch_opcode, dispatch_imm, dispatch_rdtag, dispatch_rstag, dispatch_rttag,
           dispatch_rsdata, dispatch_rtdata, dispatch_rsvalid, dispatch_rtvalid,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    input  dispatch_ready, issue_valid, issue_opcode, issue_imm, issue_rdtag, issue_rsdata, issue_rtdata
  );
endinterface

// File: rtl/queue_int.sv
// queue_int: shifting integer issue queue with CDB snoop and oldest-ready issue; ports clk, reset (async low), bus (queue_int_if.slave)
module queue_int #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 6
) (
  input logic        clk,
  input logic        reset,
  queue_int_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  typedef struct packed {
    logic [2:0]      op;
    logic [15:0]     imm;
    logic [TAGW-1:0] rd;
    logic [TAGW-1:0] rst;
    logic [TAGW-1:0] rtt;
    logic [31:0]     rsd;
    logic [31:0]     rtd;
    logic            rsv;
    logic            rtv;
  } ent_t;
  ent_t          r_q   [DEPTH];
  ent_t          w_snp [DEPTH];
  ent_t          w_nxt [DEPTH];
  ent_t          w_new;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_tail;
  logic [IW-1:0] w_sel;
  logic          w_iv;
  logic          w_acc;
  logic          w_rm;
  assign bus.dispatch_ready = r_cnt < CW'(DEPTH);
  assign w_acc  = bus.dispatch_en & bus.dispatch_ready;
  assign w_rm   = w_iv & bus.issue_ready;
  assign w_tail = w_rm ? r_cnt - 1'b1 : r_cnt;
  always_comb begin
    w_new.op  = bus.dispatch_opcode;
    w_new.imm = bus.dispatch_imm;
    w_new.rd  = bus.dispatch_rdtag;
    w_new.rst = bus.dispatch_rstag;
    w_new.rtt = bus.dispatch_rttag;
    w_new.rsv = bus.dispatch_rsvalid | (bus.cdb_valid & (bus.cdb_tag == bus.dispatch_rstag));
    w_new.rtv = bus.dispatch_rtvalid | (bus.cdb_valid & (bus.cdb_tag == bus.dispatch_rttag));
    w_new.rsd = (bus.dispatch_rsvalid | !w_new.rsv) ? bus.dispatch_rsdata : bus.cdb_data;
    w_new.rtd = (bus.dispatch_rtvalid | !w_new.rtv) ? bus.dispatch_rtdata : bus.cdb_data;
  end
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_snp[i] = r_q[i];
      if (bus.cdb_valid && !r_q[i].rsv && r_q[i].rst == bus.cdb_tag) begin
        w_snp[i].rsv = 1'b1;
        w_snp[i].rsd = bus.cdb_data;
      end
      if (bus.cdb_valid && !r_q[i].rtv && r_q[i].rtt == bus.cdb_tag) begin
        w_snp[i].rtv = 1'b1;
        w_snp[i].rtd = bus.cdb_data;
      end
    end
  end
  always_comb begin
    w_iv  = 1'b0;
    w_sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (i < int'(r_cnt) && r_q[i].rsv && r_q[i].rtv) begin
        w_iv  = 1'b1;
        w_sel = IW'(i);
      end
  end
  // entries at or above the issued slot pull from the slot above; the tail slot then takes the new dispatch
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_nxt[i] = (w_rm && i >= int'(w_sel)) ? w_snp[(i < DEPTH - 1) ? i + 1 : i] : w_snp[i];
      if (w_acc && i == int'(w_tail)) w_nxt[i] = w_new;
    end
  end
  assign bus.issue_valid  = w_iv;
  assign bus.issue_opcode = w_iv ? r_q[w_sel].op  : '0;
  assign bus.issue_imm    = w_iv ? r_q[w_sel].imm : '0;
  assign bus.issue_rdtag  = w_iv ? r_q[w_sel].rd  : '0;
  assign bus.issue_rsdata = w_iv ? r_q[w_sel].rsd : '0;
  assign bus.issue_rtdata = w_iv ? r_q[w_sel].rtd : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_q   <= '{default: '0};
    end else begin
      r_cnt <= r_cnt + CW'(w_acc) - CW'(w_rm);
      r_q   <= w_nxt;
    end
  end
endmodule

// File: tb/tb_queue_int.sv
// tb_queue_int: directed stimulus with a scoreboard of expected issues checked by a decoupled monitor
module tb_queue_int;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_pass = 0;
  int   n_tot = 0;
  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] imm;
    logic [5:0]  rd;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;
  exp_t sb[$];
  queue_int_if #(.TAGW(6)) bus();
  queue_int #(.DEPTH(4), .TAGW(6)) dut(.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  always @(negedge clk) begin
    if (reset && bus.issue_valid && bus.issue_ready) begin
      exp_t a;
      a = {bus.issue_opcode, bus.issue_imm, bus.issue_rdtag, bus.issue_rsdata, bus.issue_rtdata};
      n_tot++;
      if (sb.size() == 0) $display("FAIL issue_unexpected: got rd=%0d with no expected issue", a.rd);
      else begin
        exp_t e;
        e = sb.pop_front();
        if (a === e) n_pass++;
        else $display("FAIL issue_rd%0d: got op=%h imm=%h rd=%0d rs=%h rt=%h expected op=%h imm=%h rd=%0d rs=%h rt=%h",
                      e.rd, a.op, a.imm, a.rd, a.rs, a.rt, e.op, e.imm, e.rd, e.rs, e.rt);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_issue(input logic [2:0] op, input logic [15:0] imm, input logic [5:0] rd,
                              input logic [31:0] rs, input logic [31:0] rt);
    sb.push_back({op, imm, rd, rs, rt});
  endtask
  task automatic set_disp(input logic [2:0] op, input logic [15:0] imm, input logic [5:0] rd,
                          input logic [5:0] rst, input logic [5:0] rtt, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic rsv, input logic rtv);
    bus.dispatch_en = 1'b1;
    bus.dispatch_opcode = op;
    bus.dispatch_imm = imm;
    bus.dispatch_rdtag = rd;
    bus.dispatch_rstag = rst;
    bus.dispatch_rttag = rtt;
    bus.dispatch_rsdata = rsd;
    bus.dispatch_rtdata = rtd;
    bus.dispatch_rsvalid = rsv;
    bus.dispatch_rtvalid = rtv;
  endtask
  task automatic dispatch(input logic [2:0] op, input logic [15:0] imm, input logic [5:0] rd,
                          input logic [5:0] rst, input logic [5:0] rtt, input logic [31:0] rsd,
                          input logic [31:0] rtd, input logic rsv, input logic rtv);
    set_disp(op, imm, rd, rst, rtt, rsd, rtd, rsv, rtv);
    tick();
    bus.dispatch_en = 1'b0;
  endtask
  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag = tag;
    bus.cdb_data = data;
    tick();
    bus.cdb_valid = 1'b0;
  endtask
  initial begin
    bus.dispatch_en = 1'b0;
    bus.cdb_valid = 1'b0;
    bus.cdb_tag = '0;
    bus.cdb_data = '0;
    bus.issue_ready = 1'b0;
    set_disp(3'h0, 16'h0, 6'd0, 6'd0, 6'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    bus.dispatch_en = 1'b0;
    #12;
    chk("reset_ready", 32'(bus.dispatch_ready), 32'd1);
    chk("reset_issue_valid", 32'(bus.issue_valid), 32'd0);
    chk("reset_issue_data", {bus.issue_rsdata | bus.issue_rtdata}, 32'd0);
    reset = 1'b1;
    tick();
    // 1: ready entry issues the cycle after dispatch
    bus.issue_ready = 1'b1;
    expect_issue(3'h2, 16'h0010, 6'd5, 32'h11, 32'h22);
    dispatch(3'h2, 16'h0010, 6'd5, 6'd0, 6'd0, 32'h11, 32'h22, 1'b1, 1'b1);
    chk("t1_issue_valid", 32'(bus.issue_valid), 32'd1);
    chk("t1_rdtag", 32'(bus.issue_rdtag), 32'd5);
    tick();
    chk("t1_drained_valid", 32'(bus.issue_valid), 32'd0);
    chk("t1_drained_ready", 32'(bus.dispatch_ready), 32'd1);
    // 2: CDB capture, issuable one cycle later
    expect_issue(3'h1, 16'h0007, 6'd7, 32'hDEADBEEF, 32'h33);
    dispatch(3'h1, 16'h0007, 6'd7, 6'd3, 6'd0, 32'h0, 32'h33, 1'b0, 1'b1);
    chk("t2_wait_valid", 32'(bus.issue_valid), 32'd0);
    tick();
    chk("t2_wait_valid2", 32'(bus.issue_valid), 32'd0);
    cdb(6'd3, 32'hDEADBEEF);
    chk("t2_issue_valid", 32'(bus.issue_valid), 32'd1);
    chk("t2_rsdata", bus.issue_rsdata, 32'hDEADBEEF);
    tick();
    // 3: write-time forwarding
    expect_issue(3'h3, 16'h0009, 6'd8, 32'hA5A5A5A5, 32'h44);
    set_disp(3'h3, 16'h0009, 6'd8, 6'd9, 6'd0, 32'h0, 32'h44, 1'b0, 1'b1);
    cdb(6'd9, 32'hA5A5A5A5);
    bus.dispatch_en = 1'b0;
    chk("t3_issue_valid", 32'(bus.issue_valid), 32'd1);
    chk("t3_rsdata", bus.issue_rsdata, 32'hA5A5A5A5);
    tick();
    chk("t3_drained", 32'(bus.issue_valid), 32'd0);
    // 4: fill, ignored fifth dispatch, younger entry issues first
    dispatch(3'h1, 16'h010A, 6'd10, 6'd1, 6'd0, 32'h0, 32'hA0, 1'b0, 1'b1);
    dispatch(3'h1, 16'h010B, 6'd11, 6'd2, 6'd0, 32'h0, 32'hB0, 1'b0, 1'b1);
    dispatch(3'h1, 16'h010C, 6'd12, 6'd3, 6'd0, 32'h0, 32'hC0, 1'b0, 1'b1);
    chk("t4_ready_at3", 32'(bus.dispatch_ready), 32'd1);
    dispatch(3'h4, 16'h010D, 6'd13, 6'd4, 6'd4, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t4_full_ready", 32'(bus.dispatch_ready), 32'd0);
    dispatch(3'h1, 16'h010E, 6'd14, 6'd5, 6'd0, 32'h0, 32'hE0, 1'b0, 1'b1);
    chk("t4_ignored_ready", 32'(bus.dispatch_ready), 32'd0);
    chk("t4_none_ready", 32'(bus.issue_valid), 32'd0);
    expect_issue(3'h1, 16'h010C, 6'd12, 32'hC3, 32'hC0);
    cdb(6'd3, 32'hC3);
    chk("t4_ooo_rdtag", 32'(bus.issue_rdtag), 32'd12);
    chk("t4_still_full", 32'(bus.dispatch_ready), 32'd0);
    tick();
    chk("t4_ready_back", 32'(bus.dispatch_ready), 32'd1);
    // 5: full with issue pending blocks dispatch; later dispatch lands at the tail
    bus.issue_ready = 1'b0;
    dispatch(3'h5, 16'h0015, 6'd15, 6'd0, 6'd0, 32'h15, 32'h51, 1'b1, 1'b1);
    cdb(6'd1, 32'h1111);
    chk("t5_full", 32'(bus.dispatch_ready), 32'd0);
    chk("t5_oldest_sel", 32'(bus.issue_rdtag), 32'd10);
    expect_issue(3'h1, 16'h010A, 6'd10, 32'h1111, 32'hA0);
    bus.issue_ready = 1'b1;
    set_disp(3'h7, 16'h0077, 6'd17, 6'd0, 6'd0, 32'h77, 32'h77, 1'b1, 1'b1);
    tick();
    bus.dispatch_en = 1'b0;
    bus.issue_ready = 1'b0;
    chk("t5_ready_after", 32'(bus.dispatch_ready), 32'd1);
    chk("t5_shift_sel", 32'(bus.issue_rdtag), 32'd15);
    dispatch(3'h6, 16'h0016, 6'd16, 6'd6, 6'd0, 32'h0, 32'hD0, 1'b0, 1'b1);
    chk("t5_full_again", 32'(bus.dispatch_ready), 32'd0);
    cdb(6'd2, 32'h2222);
    cdb(6'd4, 32'h4444);
    cdb(6'd6, 32'h6666);
    expect_issue(3'h1, 16'h010B, 6'd11, 32'h2222, 32'hB0);
    expect_issue(3'h4, 16'h010D, 6'd13, 32'h4444, 32'h4444);
    expect_issue(3'h5, 16'h0015, 6'd15, 32'h15, 32'h51);
    expect_issue(3'h6, 16'h0016, 6'd16, 32'h6666, 32'hD0);
    bus.issue_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.issue_ready = 1'b0;
    chk("t5_empty_valid", 32'(bus.issue_valid), 32'd0);
    chk("t5_empty_ready", 32'(bus.dispatch_ready), 32'd1);
    // 6: asynchronous reset drops held entries without a clock edge
    dispatch(3'h2, 16'h0020, 6'd20, 6'd0, 6'd0, 32'h20, 32'h02, 1'b1, 1'b1);
    dispatch(3'h2, 16'h0021, 6'd21, 6'd0, 6'd0, 32'h21, 32'h12, 1'b1, 1'b1);
    dispatch(3'h2, 16'h0022, 6'd22, 6'd0, 6'd0, 32'h22, 32'h22, 1'b1, 1'b1);
    chk("t6_held_valid", 32'(bus.issue_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(bus.issue_valid), 32'd0);
    chk("t6_async_rdtag", 32'(bus.issue_rdtag), 32'd0);
    chk("t6_async_data", {bus.issue_rsdata | bus.issue_rtdata | 32'(bus.issue_imm) | 32'(bus.issue_opcode)}, 32'd0);
    chk("t6_async_ready", 32'(bus.dispatch_ready), 32'd1);
    #3;
    reset = 1'b1;
    tick();
    tick();
    chk("t6_post_valid", 32'(bus.issue_valid), 32'd0);
    bus.issue_ready = 1'b1;
    expect_issue(3'h7, 16'hFFFF, 6'd30, 32'h30, 32'h03);
    dispatch(3'h7, 16'hFFFF, 6'd30, 6'd0, 6'd0, 32'h30, 32'h03, 1'b1, 1'b1);
    tick();
    chk("t6_recover_valid", 32'(bus.issue_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
